// File: rtl/apb_master_bridge.sv
// APB4 initiator: single-outstanding request/response channel to APB setup/access phases.
// Optional access-phase timeout is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter type apb_req_t = struct packed {
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
  },
  parameter type apb_rsp_t = struct packed {
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;
  },
  parameter logic [2:0]  PProt         = 3'b000,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output apb_req_t              apb_req_o,
  input  apb_rsp_t              apb_rsp_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [ADDR_WIDTH-1:0] paddr_r;
  logic [DATA_WIDTH-1:0] pwdata_r;
  logic [STRB_WIDTH-1:0] pstrb_r;
  logic                  timeout_hit_s;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [CntWidth-1:0] timeout_cnt_r;

  assign timeout_hit_s = (timeout_cnt_r == CntWidth'(TimeoutCycles - 1));

  // Access-phase wait counter: cleared on the way into ACCESS, counts stalled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_cnt_r <= '0;
    end else if (state_r == SETUP) begin
      timeout_cnt_r <= '0;
    end else if ((state_r == ACCESS) && !apb_rsp_i.pready && !timeout_hit_s) begin
      timeout_cnt_r <= timeout_cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
    end else begin
      timeout_cnt_r <= timeout_cnt_r;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Transfer sequencer with all channel and bus outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= '0;
      pwdata_r    <= '0;
      pstrb_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            paddr_r     <= req_addr_i;
            pwrite_r    <= req_write_i;
            pwdata_r    <= req_wdata_i;
            // Reads never carry strobes on the bus.
            pstrb_r     <= req_write_i ? req_strb_i : '0;
            req_ready_r <= 1'b0;
            psel_r      <= 1'b1;
            penable_r   <= 1'b0;
            state_r     <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (apb_rsp_i.pready) begin
            rsp_rdata_r <= pwrite_r ? '0 : apb_rsp_i.prdata;
            rsp_err_r   <= apb_rsp_i.pslverr;
            rsp_valid_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            state_r     <= RESP;
          end else if (timeout_hit_s) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            state_r     <= RESP;
          end else begin
            state_r <= ACCESS;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;

  // Pack the registered bus fields into the request struct.
  always_comb begin
    apb_req_o         = '0;
    apb_req_o.paddr   = paddr_r;
    apb_req_o.pprot   = PProt;
    apb_req_o.psel    = psel_r;
    apb_req_o.penable = penable_r;
    apb_req_o.pwrite  = pwrite_r;
    apb_req_o.pwdata  = pwdata_r;
    apb_req_o.pstrb   = pstrb_r;
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; the completer is driven by each test.
module tb_apb_master_bridge;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } tb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } tb_rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  tb_req_t     apb_req;
  tb_rsp_t     apb_rsp;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .apb_req_t    (tb_req_t),
    .apb_rsp_t    (tb_rsp_t),
    .PProt        (3'b010),
    .TimeoutCycles(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_strb_i (req_strb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .apb_req_o  (apb_req),
    .apb_rsp_i  (apb_rsp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_strb = '0; rsp_ready = 1'b0; apb_rsp = '0;
    tick(); tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, apb_req.psel, apb_req.penable, apb_req.pwrite} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 100000",
        {req_ready, rsp_valid, rsp_err, apb_req.psel, apb_req.penable, apb_req.pwrite});
    end
    checks++;
    if ({apb_req.paddr, apb_req.pwdata, apb_req.pstrb, rsp_rdata} !== 100'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0",
        {apb_req.paddr, apb_req.pwdata, apb_req.pstrb, rsp_rdata});
    end
    checks++;
    if (apb_req.pprot !== 3'b010) begin
      errors++; $display("FAIL pprot got %b exp 010", apb_req.pprot);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    apb_rsp.pready = 1'b1; apb_rsp.prdata = 32'h1234_5678; apb_rsp.pslverr = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_c0_ready got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({apb_req.psel, apb_req.penable, req_ready, rsp_valid} !== 4'b1000) begin
      errors++; $display("FAIL wr_c1_setup got %b exp 1000", {apb_req.psel, apb_req.penable, req_ready, rsp_valid});
    end
    checks++;
    if ({apb_req.paddr, apb_req.pwrite, apb_req.pwdata, apb_req.pstrb} !== {32'h10, 1'b1, 32'hA5A5_0001, 4'hF}) begin
      errors++; $display("FAIL wr_c1_bus got %h exp %h",
        {apb_req.paddr, apb_req.pwrite, apb_req.pwdata, apb_req.pstrb}, {32'h10, 1'b1, 32'hA5A5_0001, 4'hF});
    end
    tick();
    checks++;
    if ({apb_req.psel, apb_req.penable, req_ready, rsp_valid} !== 4'b1100) begin
      errors++; $display("FAIL wr_c2_access got %b exp 1100", {apb_req.psel, apb_req.penable, req_ready, rsp_valid});
    end
    tick();
    checks++;
    if ({apb_req.psel, apb_req.penable, req_ready, rsp_valid} !== 4'b0001) begin
      errors++; $display("FAIL wr_c3_resp got %b exp 0001", {apb_req.psel, apb_req.penable, req_ready, rsp_valid});
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== 33'd0) begin
      errors++; $display("FAIL wr_rsp_data got %h exp 0", {rsp_err, rsp_rdata});
    end
    tick();
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL wr_c4_idle got %b exp 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_read_wait();
    apb_rsp.pready = 1'b0; apb_rsp.prdata = 32'hBAD0_BAD0; apb_rsp.pslverr = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b0, 32'h0000_0014, 32'hFFFF_FFFF, 4'hF);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({apb_req.paddr, apb_req.pwrite, apb_req.pstrb, apb_req.psel, apb_req.penable} !== {32'h14, 1'b0, 4'h0, 2'b10}) begin
      errors++; $display("FAIL rd_setup got %h exp %h",
        {apb_req.paddr, apb_req.pwrite, apb_req.pstrb, apb_req.psel, apb_req.penable}, {32'h14, 1'b0, 4'h0, 2'b10});
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++;
      if ({apb_req.paddr, apb_req.psel, apb_req.penable, rsp_valid} !== {32'h14, 3'b110}) begin
        errors++; $display("FAIL rd_wait%0d got %h exp %h", i,
          {apb_req.paddr, apb_req.psel, apb_req.penable, rsp_valid}, {32'h14, 3'b110});
      end
    end
    tick();
    apb_rsp.pready = 1'b1; apb_rsp.prdata = 32'hDEAD_BEEF; apb_rsp.pslverr = 1'b0;
    checks++;
    if ({apb_req.paddr, apb_req.psel, apb_req.penable, rsp_valid} !== {32'h14, 3'b110}) begin
      errors++; $display("FAIL rd_c5 got %h exp %h",
        {apb_req.paddr, apb_req.psel, apb_req.penable, rsp_valid}, {32'h14, 3'b110});
    end
    tick();
    apb_rsp.pready = 1'b0; apb_rsp.prdata = 32'h0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, apb_req.psel} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL rd_rsp got %h exp %h", {rsp_valid, rsp_err, rsp_rdata, apb_req.psel},
        {2'b10, 32'hDEAD_BEEF, 1'b0});
    end
    tick();
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL rd_idle got %b exp 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_err_hold();
    apb_rsp.pready = 1'b1; apb_rsp.prdata = 32'h0000_00C3; apb_rsp.pslverr = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0018, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    apb_rsp.pslverr = 1'b0; apb_rsp.prdata = 32'h7777_7777;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {2'b11, 32'h0000_00C3, 1'b0}) begin
        errors++; $display("FAIL err_hold%0d got %h exp %h", i, {rsp_valid, rsp_err, rsp_rdata, req_ready},
          {2'b11, 32'h0000_00C3, 1'b0});
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL err_release got %b exp 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_reset_mid();
    apb_rsp.pready = 1'b0; apb_rsp.prdata = 32'h0; apb_rsp.pslverr = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0000_001C, 32'h5555_AAAA, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if ({apb_req.psel, apb_req.penable} !== 2'b11) begin
      errors++; $display("FAIL rstmid_access got %b exp 11", {apb_req.psel, apb_req.penable});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apb_rsp.pready = 1'b1;
    checks++;
    if ({apb_req.psel, apb_req.penable, req_ready, rsp_valid, apb_req.paddr} !== {4'b0010, 32'h0}) begin
      errors++; $display("FAIL rstmid_after got %h exp %h",
        {apb_req.psel, apb_req.penable, req_ready, rsp_valid, apb_req.paddr}, {4'b0010, 32'h0});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rsp_valid, apb_req.psel} !== 2'b00) begin
        errors++; $display("FAIL rstmid_norsp%0d got %b exp 00", i, {rsp_valid, apb_req.psel});
      end
    end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    apb_rsp.pready = 1'b0; apb_rsp.prdata = 32'hFFFF_0000; apb_rsp.pslverr = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      tick();
      checks++;
      if ({apb_req.psel, apb_req.penable, rsp_valid} !== 3'b110) begin
        errors++; $display("FAIL to_wait%0d got %b exp 110", i, {apb_req.psel, apb_req.penable, rsp_valid});
      end
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, apb_req.psel} !== {2'b11, 32'h0, 1'b0}) begin
      errors++; $display("FAIL to_abort got %h exp %h", {rsp_valid, rsp_err, rsp_rdata, apb_req.psel},
        {2'b11, 32'h0, 1'b0});
    end
    tick();
    issue(1'b0, 32'h0000_0024, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 2; i <= 8; i++) tick();
    tick();
    apb_rsp.pready = 1'b1; apb_rsp.prdata = 32'h0BAD_F00D;
    checks++;
    if ({apb_req.psel, apb_req.penable, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL to_limit got %b exp 110", {apb_req.psel, apb_req.penable, rsp_valid});
    end
    tick();
    apb_rsp.pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL to_pready_wins got %h exp %h", {rsp_valid, rsp_err, rsp_rdata},
        {2'b10, 32'h0BAD_F00D});
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    apb_rsp.pready = 1'b0; apb_rsp.prdata = 32'h0; apb_rsp.pslverr = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if ({apb_req.psel, apb_req.penable, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL nto_wait got %b exp 110", {apb_req.psel, apb_req.penable, rsp_valid});
    end
    apb_rsp.pready = 1'b1; apb_rsp.prdata = 32'h0000_4242;
    tick();
    apb_rsp.pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0000_4242}) begin
      errors++; $display("FAIL nto_rsp got %h exp %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0000_4242});
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    apb_rsp.pready = 1'b1; apb_rsp.prdata = 32'h1111_2222; apb_rsp.pslverr = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0000_0030, 32'hCAFE_0001, 4'h3);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_c0_ready got %b exp 1", req_ready); end
    tick();
    issue(1'b0, 32'h0000_0034, 32'h0, 4'hF);
    checks++;
    if ({apb_req.psel, apb_req.paddr, apb_req.pstrb} !== {1'b1, 32'h30, 4'h3}) begin
      errors++; $display("FAIL b2b_first_setup got %h exp %h", {apb_req.psel, apb_req.paddr, apb_req.pstrb},
        {1'b1, 32'h30, 4'h3});
    end
    tick();
    tick();
    checks++;
    if ({rsp_valid, req_ready, rsp_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL b2b_first_rsp got %h exp %h", {rsp_valid, req_ready, rsp_rdata}, {2'b10, 32'h0});
    end
    tick();
    checks++;
    if ({req_ready, rsp_valid, apb_req.psel} !== 3'b100) begin
      errors++; $display("FAIL b2b_c4_ready got %b exp 100", {req_ready, rsp_valid, apb_req.psel});
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({apb_req.psel, apb_req.penable, apb_req.pwrite, apb_req.paddr, apb_req.pstrb} !== {3'b100, 32'h34, 4'h0}) begin
      errors++; $display("FAIL b2b_second_setup got %h exp %h",
        {apb_req.psel, apb_req.penable, apb_req.pwrite, apb_req.paddr, apb_req.pstrb}, {3'b100, 32'h34, 4'h0});
    end
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1111_2222}) begin
      errors++; $display("FAIL b2b_second_rsp got %h exp %h", {rsp_valid, rsp_err, rsp_rdata},
        {2'b10, 32'h1111_2222});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_err_hold();
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
